// File: rtl/tsc_pkg.sv
// Shared defaults and entry format for timestamp_capture.
// TSC_BOTH_EDGES_EN widens each entry by an edge-polarity bit.
package tsc_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int DEPTH_DEF       = 4;
    localparam int SYNC_STAGES_DEF = 2;

    function automatic int ts_w(input int cnt_w);
`ifdef TSC_BOTH_EDGES_EN
        return cnt_w + 1;
`else
        return cnt_w;
`endif
    endfunction

    localparam int TS_W_DEF = ts_w(CNT_W_DEF);

    // Entry layout when both edges are captured: MSB is 1 for rising, 0 for falling.
    typedef struct packed {
        logic                 rise;
        logic [CNT_W_DEF-1:0] cnt;
    } tsc_entry_t;

endpackage

// File: rtl/event_sync.sv
// Multi-flop synchronizer for an asynchronous event, followed by a delay flop
// that yields single-cycle rise/fall pulses on the synchronized signal.
module event_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic event_i,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_i};
            dly_q  <= sync_s;
        end
    end

    assign rise_o = sync_s & ~dly_q;
    assign fall_o = ~sync_s & dly_q;

endmodule

// File: rtl/timestamp_capture.sv
// Captures cnt_i on synchronized event edges into a show-ahead FIFO.
// Define TSC_BOTH_EDGES_EN to also capture falling edges (entries gain an edge MSB).
module timestamp_capture
    import tsc_pkg::*;
#(
    parameter  int CNT_W       = CNT_W_DEF,
    parameter  int DEPTH       = DEPTH_DEF,
    parameter  int SYNC_STAGES = SYNC_STAGES_DEF,
    localparam int TS_W        = ts_w(CNT_W),
    localparam int LVL_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             nrst_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             event_i,
    input  logic             cap_en_i,
    input  logic             clr_i,
    output logic             ts_valid_o,
    output logic [TS_W-1:0]  ts_data_o,
    input  logic             ts_ready_i,
    output logic [LVL_W-1:0] level_o,
    output logic             ovf_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic             rise;
    logic             fall;
    logic             cap_req;
    logic [TS_W-1:0]  entry;

    logic [TS_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ovf_q, ovf_d;

    logic             full;
    logic             pop;
    logic             wr_en;

    event_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_event_sync (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .event_i(event_i),
        .rise_o (rise),
        .fall_o (fall)
    );

`ifdef TSC_BOTH_EDGES_EN
    assign cap_req = cap_en_i & (rise | fall);
    assign entry   = {rise, cnt_i};
`else
    logic unused_fall;
    assign unused_fall = fall;
    assign cap_req     = cap_en_i & rise;
    assign entry       = cnt_i;
`endif

    assign full  = (level_q == LVL_W'(DEPTH));
    assign pop   = (level_q != '0) & ts_ready_i;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
    assign wr_en = cap_req & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
            level_d = level_q + LVL_W'(wr_en) - LVL_W'(pop);
            if (cap_req && full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !clr_i) mem_q[wr_ptr_q] <= entry;
    end

    assign ts_valid_o = (level_q != '0);
    assign ts_data_o  = ts_valid_o ? mem_q[rd_ptr_q] : '0;
    assign level_o    = level_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_timestamp_capture.sv
// Directed self-checking bench for timestamp_capture (DEPTH=4, SYNC_STAGES=2).
module tb_timestamp_capture;
    import tsc_pkg::*;

    localparam int TS_W = ts_w(CNT_W_DEF);

    logic            clk_i = 1'b0;
    logic            nrst_i;
    logic [15:0]     cnt_i;
    logic            event_i;
    logic            cap_en_i;
    logic            clr_i;
    logic            ts_valid_o;
    logic [TS_W-1:0] ts_data_o;
    logic            ts_ready_i;
    logic [2:0]      level_o;
    logic            ovf_o;

    int checks = 0;
    int errors = 0;
    int n      = 0;

    timestamp_capture #(
        .CNT_W      (16),
        .DEPTH      (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .cnt_i     (cnt_i),
        .event_i   (event_i),
        .cap_en_i  (cap_en_i),
        .clr_i     (clr_i),
        .ts_valid_o(ts_valid_o),
        .ts_data_o (ts_data_o),
        .ts_ready_i(ts_ready_i),
        .level_o   (level_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // After tick n, cnt_i holds the value the DUT samples at edge n+1.
    task automatic tick();
        @(posedge clk_i);
        #1;
        n++;
        cnt_i = cnt_i + 16'd1;
    endtask

    task automatic pulse(input int h, input int l);
        event_i = 1'b1;
        repeat (h) tick();
        event_i = 1'b0;
        repeat (l) tick();
    endtask

`ifdef TSC_BOTH_EDGES_EN
    tsc_entry_t e;
`endif

    initial begin
        nrst_i     = 1'b0;
        cnt_i      = 16'h0101;
        event_i    = 1'b0;
        cap_en_i   = 1'b1;
        clr_i      = 1'b0;
        ts_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst_valid", ts_valid_o, 0);
        check("rst_data",  ts_data_o,  0);
        check("rst_level", level_o,    0);
        check("rst_ovf",   ovf_o,      0);
        @(negedge clk_i);
        nrst_i = 1'b1;
        n = 0;

`ifdef TSC_BOTH_EDGES_EN
        repeat (2) tick();
        event_i = 1'b1;
        repeat (3) tick();
        e = '{rise: 1'b1, cnt: 16'h0105};
        check("be_level1", level_o, 1);
        check("be_rise_data", ts_data_o, e);
        repeat (3) tick();
        event_i = 1'b0;
        repeat (3) tick();
        check("be_level2", level_o, 2);
        tick();
        check("be_head_rise", ts_data_o, e);
        ts_ready_i = 1'b1;
        tick();
        e = '{rise: 1'b0, cnt: 16'h010B};
        check("be_fall_data", ts_data_o, e);
        tick();
        ts_ready_i = 1'b0;
        check("be_level0", level_o, 0);
        check("be_valid0", ts_valid_o, 0);
        check("be_ovf0", ovf_o, 0);
`else
        // First capture: rise before edge 10, written at edge 12.
        repeat (9) tick();
        event_i = 1'b1;
        repeat (2) tick();
        check("lat_level_e11", level_o, 0);
        tick();
        check("lat_level_e12", level_o, 1);
        check("lat_valid_e12", ts_valid_o, 1);
        check("lat_data_e12", ts_data_o, 16'h010C);
        tick();
        event_i = 1'b0;
        repeat (4) tick();
        ts_ready_i = 1'b1;
        tick();
        ts_ready_i = 1'b0;
        check("pop_valid", ts_valid_o, 0);
        check("pop_data", ts_data_o, 0);
        check("pop_level", level_o, 0);

        // Five events, no reads: fifth dropped.
        repeat (5) pulse(2, 2);
        check("ovf_level", level_o, 4);
        check("ovf_flag", ovf_o, 1);
        ts_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_readback", ts_data_o, 16'h0115 + 16'(4 * i));
            tick();
        end
        ts_ready_i = 1'b0;
        check("ovf_drain_level", level_o, 0);
        check("ovf_sticky", ovf_o, 1);

        // Clear with three entries and overflow set.
        repeat (3) pulse(2, 2);
        check("clr_pre_level", level_o, 3);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        check("clr_level", level_o, 0);
        check("clr_ovf", ovf_o, 0);
        check("clr_valid", ts_valid_o, 0);

        // Full FIFO with capture and pop on the same edge.
        repeat (4) pulse(2, 2);
        check("full_level", level_o, 4);
        check("full_head", ts_data_o, 16'h013A);
        event_i = 1'b1;
        repeat (2) tick();
        ts_ready_i = 1'b1;
        tick();
        ts_ready_i = 1'b0;
        event_i = 1'b0;
        check("fullpop_level", level_o, 4);
        check("fullpop_ovf", ovf_o, 0);
        check("fullpop_head", ts_data_o, 16'h013E);
        repeat (2) tick();
        ts_ready_i = 1'b1;
        check("fullpop_rd0", ts_data_o, 16'h013E);
        tick();
        check("fullpop_rd1", ts_data_o, 16'h0142);
        tick();
        check("fullpop_rd2", ts_data_o, 16'h0146);
        tick();
        check("fullpop_rd3", ts_data_o, 16'h014A);
        tick();
        ts_ready_i = 1'b0;
        check("fullpop_empty", level_o, 0);

        // Count wrap stored verbatim.
        cnt_i = 16'hFFFD;
        pulse(2, 2);
        cnt_i = 16'hFFFE;
        pulse(2, 2);
        check("wrap_level", level_o, 2);
        check("wrap_ffff", ts_data_o, 16'hFFFF);
        ts_ready_i = 1'b1;
        tick();
        check("wrap_0000", ts_data_o, 16'h0000);
        tick();
        ts_ready_i = 1'b0;
        check("wrap_empty", ts_valid_o, 0);

        // Capture disabled.
        cap_en_i = 1'b0;
        pulse(2, 2);
        cap_en_i = 1'b1;
        repeat (2) tick();
        check("capdis_level", level_o, 0);
        check("capdis_valid", ts_valid_o, 0);

        // Asynchronous reset mid-operation, event held high through reset.
        pulse(2, 2);
        check("arst_pre_level", level_o, 1);
        event_i = 1'b1;
        nrst_i  = 1'b0;
        #1;
        check("arst_level", level_o, 0);
        check("arst_valid", ts_valid_o, 0);
        check("arst_data", ts_data_o, 0);
        repeat (2) tick();
        @(negedge clk_i);
        nrst_i = 1'b1;
        repeat (2) tick();
        check("arst_evt_e2", level_o, 0);
        tick();
        check("arst_evt_e3", level_o, 1);
        event_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timestamp_capture.md
# timestamp_capture

Captures the free-running 16-bit timebase count at each rising edge of an asynchronous external event and queues the timestamps for readout. Sits directly downstream of the timebase counter, taking its count output on `cnt_i`. Provides a show-ahead FIFO with a valid/ready read port for the host-side timing logic.

## Interface
- `CNT_W`, 16: width of the captured count.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `SYNC_STAGES`, 2: flops in the event synchronizer; at least 2.
- `clk_i`  in  1: single clock domain.
- `nrst_i`  in  1: reset, asynchronous, active-low.
- `cnt_i`  in  CNT_W: timebase count from the counter stage.
- `event_i`  in  1: asynchronous external event.
- `cap_en_i`  in  1: capture enable. When low, no new captures; FIFO contents are retained.
- `clr_i`  in  1: synchronous flush of the FIFO and the overflow flag.
- `ts_valid_o`  out  1: FIFO not empty.
- `ts_data_o`  out  TS_W: head entry. TS_W = CNT_W, or CNT_W+1 with the macro defined.
- `ts_ready_i`  in  1: consumer accepts the head entry.
- `level_o`  out  clog2(DEPTH+1): number of stored entries.
- `ovf_o`  out  1: sticky flag; set when a capture is lost.

## Operation
- `event_i` passes through a SYNC_STAGES-flop synchronizer, then a one-flop delay used for edge detection.
- Capture request: a rising edge on the synchronized signal while `cap_en_i`=1.
- Each accepted capture writes the current `cnt_i` to the tail of the FIFO.
- Pop: occurs when `ts_valid_o`&&`ts_ready_i`; the head advances.
- Capture with FIFO not full: the entry is written.
- Capture with FIFO full and no pop that cycle: the entry is dropped and `ovf_o` is set.
- Capture and pop in the same cycle while full: the capture is accepted and `level_o` is unchanged.
- Capture and pop in the same cycle while empty: the pop is impossible (`ts_valid_o`=0); the capture is written.
- `clr_i`=1 has the highest priority:
  - pointers, `level_o` and `ovf_o` go to 0;
  - any capture or pop in that cycle is discarded.
- `ovf_o` is cleared only by `clr_i` or reset.
- `ts_data_o` is driven to 0 while the FIFO is empty.
- `cnt_i` is treated as opaque: wrap-around from 0xFFFF to 0x0000, and counter resets, are stored verbatim.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.

## Timing
- Reset values: `ts_valid_o`=0, `ts_data_o`=0, `level_o`=0, `ovf_o`=0. Synchronizer and edge flops reset to 0.
- An `event_i` that is high while `nrst_i` is low produces one capture after reset release, once it has propagated through the synchronizer.
- Capture latency: `event_i` rises before clock edge k. The FIFO write then happens at edge k+SYNC_STAGES, storing the `cnt_i` sampled at that edge.
- From that same edge, `ts_valid_o` is high and `level_o` is incremented.
- Minimum event spacing for distinct captures: 2 cycles high plus 2 cycles low on the synchronized signal. Shorter pulses may be lost; this is not flagged.
- Show-ahead read: after a pop at edge n, `ts_data_o` shows the next entry from edge n.
- Throughput: one capture and one pop per cycle.
- Reset asserted mid-operation: all state is cleared asynchronously. Queued entries are lost.

## Configuration
- `TSC_BOTH_EDGES_EN` defined:
  - falling edges are also captured;
  - TS_W = CNT_W+1, with MSB = 1 for a rising edge and 0 for a falling edge.
- `TSC_BOTH_EDGES_EN` undefined: rising edges only, and TS_W = CNT_W.

## Structure
- Shared package `tsc_pkg` holds:
  - default `CNT_W`, `DEPTH`, `SYNC_STAGES`;
  - the TS_W derivation;
  - the entry type (edge bit + count).
- Sub-module `event_sync`: synchronizer plus edge detector. Outputs `rise_o` and `fall_o` pulses.
- FIFO storage and pointers live in the top module.

## Test plan
- Reset, then `cnt_i` ramping from 0x0100 with `event_i` pulsed high for 4 cycles with the rise before edge 10 → one entry of 0x010C (edge 12). `level_o`=1.
- 5 events with no reads, DEPTH=4 → `level_o`=4, the 5th capture is dropped, `ovf_o`=1, and the first 4 values read back in order.
- FIFO full plus a simultaneous event and pop → the new entry is accepted, `level_o` stays 4, `ovf_o` stays 0.
- `cnt_i` wrapping 0xFFFE→0x0001 across events → stored values 0xFFFF and 0x0000 are preserved exactly.
- `cap_en_i`=0 during an event → no entry. `clr_i` with 3 entries and `ovf_o`=1 → `level_o`=0, `ovf_o`=0, `ts_valid_o`=0 the next cycle.
- With `TSC_BOTH_EDGES_EN`, an event high for 6 cycles → two entries: MSB 1 with count c, then MSB 0 with count c+6.
